// File: rtl/timepulse_pkg.sv
// Shared types and constants for the time-pulse monitor family.
package timepulse_pkg;

  // Monitor tracking state.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    JAM   = 2'd2
  } tp_state_e;

  localparam int NUM_T            = 12;
  localparam int MAX_HOLD_DEFAULT = 64;

  localparam logic [3:0] TIDX_NONE  = 4'd0;
  localparam logic [3:0] TIDX_FIRST = 4'd1;
  localparam logic [3:0] TIDX_LAST  = 4'd12;

  // Index that legally follows idx on the T01..T12 ring.
  function automatic logic [3:0] tidx_succ(input logic [3:0] idx);
    logic [3:0] nxt;
    if (idx == TIDX_LAST) begin
      nxt = TIDX_FIRST;
    end else begin
      nxt = idx + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tp_onehot_decode.sv
// Maps twelve active-low time pulses to a 1..12 index; 0 means none or illegal.
module tp_onehot_decode
  import timepulse_pkg::*;
(
  input  logic [NUM_T-1:0] t_n,
  output logic [3:0]       tidx,
  output logic             illegal
);

  logic [3:0] low_cnt_s;
  logic [3:0] raw_idx_s;

  // Count low pulses and remember the (highest) low position.
  always_comb begin
    low_cnt_s = 4'd0;
    raw_idx_s = TIDX_NONE;
    for (int k = 0; k < NUM_T; k++) begin
      if (t_n[k] == 1'b0) begin
        low_cnt_s = low_cnt_s + 4'd1;
        raw_idx_s = 4'(k + 1);
      end else begin
        low_cnt_s = low_cnt_s;
      end
    end
  end

  // Only a single low pulse yields a usable index.
  always_comb begin
    if (low_cnt_s > 4'd1) begin
      tidx    = TIDX_NONE;
      illegal = 1'b1;
    end else begin
      tidx    = raw_idx_s;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/timepulse_monitor.sv
// Consumer-side checker for the timer's time-pulse ring: locks on T01,
// counts completed memory-cycle times and raises sticky alarms.
module timepulse_monitor
  import timepulse_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic [NUM_T-1:0] T_n,
  input  logic             GOJAM,
  input  logic             STOP,
  input  logic             ERR_CLR,
  output logic [3:0]       TIDX,
  output logic             NEWT,
  output logic             LOCKED,
  output logic [CNT_W-1:0] MCT_CNT,
  output logic             SEQ_ERR,
  output logic             CODE_ERR,
  output logic             STALL_ERR
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [CNT_W-1:0]  MCT_ONE  = CNT_W'(1);

  logic [NUM_T-1:0]  t_n_r;
  logic              gojam_r, stop_r;
  logic [3:0]        idx_s;
  logic              illegal_s;

  tp_state_e         state_r, state_nxt_s;
  logic [3:0]        prev_r, prev_nxt_s;
  logic [HOLD_W-1:0] hold_r, hold_nxt_s, hold_inc_s;
  logic              gap_r, gap_nxt_s;
  logic              step_s, wrap_s, seq_s, code_s, stall_s;

  logic [3:0]        tidx_r;
  logic              newt_r, locked_r;
  logic [CNT_W-1:0]  mct_r, mct_nxt_s;
  logic              seq_err_r, code_err_r, stall_err_r;
  logic              seq_err_nxt_s, code_err_nxt_s, stall_err_nxt_s;

  // Stage 1: sample the timer bus.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      t_n_r   <= {NUM_T{1'b1}};
      gojam_r <= 1'b0;
      stop_r  <= 1'b0;
    end else begin
      t_n_r   <= T_n;
      gojam_r <= GOJAM;
      stop_r  <= STOP;
    end
  end

  tp_onehot_decode u_decode (
    .t_n     (t_n_r),
    .tidx    (idx_s),
    .illegal (illegal_s)
  );

  assign hold_inc_s = stop_r ? hold_r : (hold_r + HOLD_ONE);

  // Next-state and tracking-event logic; a sampled GOJAM overrides all else.
  always_comb begin
    state_nxt_s = state_r;
    prev_nxt_s  = prev_r;
    hold_nxt_s  = hold_r;
    gap_nxt_s   = gap_r;
    step_s      = 1'b0;
    wrap_s      = 1'b0;
    seq_s       = 1'b0;
    code_s      = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      SYNC: begin
        if (gojam_r) begin
          state_nxt_s = JAM;
        end else if (idx_s == TIDX_FIRST) begin
          state_nxt_s = TRACK;
          prev_nxt_s  = TIDX_FIRST;
          hold_nxt_s  = HOLD_ZERO;
          gap_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      TRACK: begin
        if (gojam_r) begin
          state_nxt_s = JAM;
        end else if (illegal_s) begin
          code_s      = 1'b1;
          state_nxt_s = SYNC;
        end else if ((idx_s == TIDX_NONE) && gap_r) begin
          code_s      = 1'b1;
          state_nxt_s = SYNC;
        end else if ((idx_s == TIDX_NONE) || (idx_s == prev_r)) begin
          // Single gap cycles and repeats of the current pulse both age it.
          gap_nxt_s  = (idx_s == TIDX_NONE);
          hold_nxt_s = hold_inc_s;
          if (hold_inc_s == HOLD_LIM) begin
            stall_s     = 1'b1;
            state_nxt_s = SYNC;
          end else begin
            state_nxt_s = TRACK;
          end
        end else if (idx_s == tidx_succ(prev_r)) begin
          step_s     = 1'b1;
          wrap_s     = (prev_r == TIDX_LAST);
          prev_nxt_s = idx_s;
          hold_nxt_s = HOLD_ZERO;
          gap_nxt_s  = 1'b0;
        end else begin
          seq_s       = 1'b1;
          state_nxt_s = SYNC;
        end
      end
      JAM: begin
        code_s = (idx_s != TIDX_NONE) && (idx_s != TIDX_LAST);
        if (gojam_r) begin
          state_nxt_s = JAM;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      default: begin
        state_nxt_s = SYNC;
      end
    endcase
  end

  // Output next values: counter, sticky flags (new errors beat ERR_CLR).
  always_comb begin
    mct_nxt_s       = wrap_s ? (mct_r + MCT_ONE) : mct_r;
    seq_err_nxt_s   = (ERR_CLR ? 1'b0 : seq_err_r)   | seq_s;
    code_err_nxt_s  = (ERR_CLR ? 1'b0 : code_err_r)  | code_s;
    stall_err_nxt_s = (ERR_CLR ? 1'b0 : stall_err_r) | stall_s;
  end

  // Stage 2: state, tracking context and registered outputs.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_r     <= SYNC;
      prev_r      <= TIDX_NONE;
      hold_r      <= HOLD_ZERO;
      gap_r       <= 1'b0;
      tidx_r      <= TIDX_NONE;
      newt_r      <= 1'b0;
      locked_r    <= 1'b0;
      mct_r       <= {CNT_W{1'b0}};
      seq_err_r   <= 1'b0;
      code_err_r  <= 1'b0;
      stall_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prev_r      <= prev_nxt_s;
      hold_r      <= hold_nxt_s;
      gap_r       <= gap_nxt_s;
      tidx_r      <= idx_s;
      newt_r      <= step_s;
      locked_r    <= (state_nxt_s == TRACK);
      mct_r       <= mct_nxt_s;
      seq_err_r   <= seq_err_nxt_s;
      code_err_r  <= code_err_nxt_s;
      stall_err_r <= stall_err_nxt_s;
    end
  end

  assign TIDX      = tidx_r;
  assign NEWT      = newt_r;
  assign LOCKED    = locked_r;
  assign MCT_CNT   = mct_r;
  assign SEQ_ERR   = seq_err_r;
  assign CODE_ERR  = code_err_r;
  assign STALL_ERR = stall_err_r;

endmodule

// File: tb/tb_timepulse_monitor.sv
// Self-checking bench for timepulse_monitor: directed scenarios plus
// randomized ring traffic against a behavioural model.
module tb_timepulse_monitor;

  localparam int MAX_HOLD = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] t_n;
  logic        gojam, stop, err_clr;

  logic [3:0]  tidx_a, tidx_b;
  logic        newt_a, newt_b, locked_a, locked_b;
  logic [15:0] mct_a;
  logic [3:0]  mct_b;
  logic        seq_a, code_a, stall_a, seq_b, code_b, stall_b;

  int tests = 0;
  int fails = 0;
  int newt_tally = 0;

  // Behavioural model state.
  logic [11:0] s1_tn;
  logic        s1_gj, s1_st;
  bit          m_locked, m_jammed, m_gap, m_newt, m_seq, m_code, m_stall;
  int          m_prev, m_hold, m_tidx, m_mct;

  always #5 clk = ~clk;

  timepulse_monitor #(.MAX_HOLD(MAX_HOLD), .CNT_W(16)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .T_n(t_n), .GOJAM(gojam), .STOP(stop),
    .ERR_CLR(err_clr), .TIDX(tidx_a), .NEWT(newt_a), .LOCKED(locked_a),
    .MCT_CNT(mct_a), .SEQ_ERR(seq_a), .CODE_ERR(code_a), .STALL_ERR(stall_a)
  );

  timepulse_monitor #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut4 (
    .SIM_CLK(clk), .SIM_RST(rst), .T_n(t_n), .GOJAM(gojam), .STOP(stop),
    .ERR_CLR(err_clr), .TIDX(tidx_b), .NEWT(newt_b), .LOCKED(locked_b),
    .MCT_CNT(mct_b), .SEQ_ERR(seq_b), .CODE_ERR(code_b), .STALL_ERR(stall_b)
  );

  // Tally NEWT strobes of the main instance, settled after each edge.
  always @(posedge clk) begin
    #2;
    if (newt_a === 1'b1) newt_tally++;
  end

  function automatic logic [11:0] tp(input int k);
    logic [11:0] v;
    v = 12'hFFF;
    if (k >= 1 && k <= 12) v[k-1] = 1'b0;
    return v;
  endfunction

  // Model of one clock edge, derived from the ring rules.
  task automatic model_edge(input logic r, input logic [11:0] tn, input logic gj,
                            input logic st, input logic clr);
    int lows, idx;
    bit ill, nseq, ncode, nstall;
    if (r) begin
      s1_tn = 12'hFFF; s1_gj = 0; s1_st = 0;
      m_locked = 0; m_jammed = 0; m_gap = 0; m_newt = 0;
      m_seq = 0; m_code = 0; m_stall = 0;
      m_prev = 0; m_hold = 0; m_tidx = 0; m_mct = 0;
      return;
    end
    lows = 0; idx = 0;
    for (int k = 1; k <= 12; k++) if (s1_tn[k-1] == 1'b0) begin lows++; idx = k; end
    ill = (lows > 1);
    if (ill) idx = 0;
    nseq = 0; ncode = 0; nstall = 0; m_newt = 0; m_tidx = idx;
    if (m_jammed && idx != 0 && idx != 12) ncode = 1;
    if (s1_gj) begin
      m_jammed = 1; m_locked = 0;
    end else if (m_jammed) begin
      m_jammed = 0;
    end else if (!m_locked) begin
      if (idx == 1) begin m_locked = 1; m_prev = 1; m_hold = 0; m_gap = 0; end
    end else if (ill || (idx == 0 && m_gap)) begin
      ncode = 1; m_locked = 0;
    end else if (idx == 0 || idx == m_prev) begin
      m_gap = (idx == 0);
      if (!s1_st) m_hold++;
      if (m_hold >= MAX_HOLD) begin nstall = 1; m_locked = 0; end
    end else if (idx == (m_prev % 12) + 1) begin
      m_newt = 1;
      if (m_prev == 12) m_mct++;
      m_prev = idx; m_hold = 0; m_gap = 0;
    end else begin
      nseq = 1; m_locked = 0;
    end
    m_seq   = (clr ? 1'b0 : m_seq)   | nseq;
    m_code  = (clr ? 1'b0 : m_code)  | ncode;
    m_stall = (clr ? 1'b0 : m_stall) | nstall;
    s1_tn = tn; s1_gj = gj; s1_st = st;
  endtask

  // Drive one cycle of inputs, advance the model, land on the next negedge.
  task automatic cyc(input logic [11:0] tn, input logic gj, input logic st, input logic clr);
    t_n = tn; gojam = gj; stop = st; err_clr = clr;
    model_edge(rst, tn, gj, st, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ring(input int hold);
    for (int k = 1; k <= 12; k++) repeat (hold) cyc(tp(k), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc(12'hFFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tests++;
    if ({tidx_a, newt_a, locked_a, mct_a, seq_a, code_a, stall_a} !== 25'd0) begin
      $display("FAIL reset_state: got %h want 0", {tidx_a, newt_a, locked_a, mct_a, seq_a, code_a, stall_a});
      fails++;
    end
  endtask

  task automatic test_rings();
    int lock_at, n0;
    lock_at = -1; n0 = newt_tally;
    for (int i = 0; i < 8; i++) begin
      cyc(tp(1), 1'b0, 1'b0, 1'b0);
      if (lock_at < 0 && locked_a === 1'b1) lock_at = i;
    end
    for (int k = 2; k <= 12; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    ring(8); ring(8);
    tests++;
    if (lock_at !== 1) begin $display("FAIL lock_latency: got %0d want 1", lock_at); fails++; end
    tests++;
    if (newt_tally - n0 !== 35) begin $display("FAIL newt_count: got %0d want 35", newt_tally - n0); fails++; end
    tests++;
    if (mct_a !== 16'd2 || m_mct != 2) begin $display("FAIL mct_three_rings: got %0d want 2", mct_a); fails++; end
    tests++;
    if ({seq_a, code_a, stall_a, locked_a} !== 4'b0001) begin
      $display("FAIL ring_flags: got %b want 0001", {seq_a, code_a, stall_a, locked_a}); fails++;
    end
  endtask

  task automatic test_skip();
    for (int k = 1; k <= 4; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    cyc(tp(6), 1'b0, 1'b0, 1'b0);
    tests++;
    if ({seq_a, locked_a} !== 2'b01) begin $display("FAIL skip_early: got %b want 01", {seq_a, locked_a}); fails++; end
    cyc(tp(6), 1'b0, 1'b0, 1'b0);
    tests++;
    if ({seq_a, locked_a} !== 2'b10) begin $display("FAIL skip_seq_err: got %b want 10", {seq_a, locked_a}); fails++; end
    repeat (6) cyc(tp(6), 1'b0, 1'b0, 1'b0);
    for (int k = 7; k <= 12; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    cyc(tp(1), 1'b0, 1'b0, 1'b0);
    cyc(tp(1), 1'b0, 1'b0, 1'b0);
    tests++;
    if ({seq_a, locked_a} !== 2'b11) begin $display("FAIL skip_relock: got %b want 11", {seq_a, locked_a}); fails++; end
    cyc(tp(1), 1'b0, 1'b0, 1'b1);
    tests++;
    if (seq_a !== 1'b0) begin $display("FAIL skip_clear: got %b want 0", seq_a); fails++; end
  endtask

  task automatic test_code();
    logic [11:0] ill;
    ill = tp(3) & tp(4);
    repeat (6) cyc(tp(1), 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(tp(2), 1'b0, 1'b0, 1'b0);
    cyc(ill, 1'b0, 1'b0, 1'b0);
    cyc(ill, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({code_a, tidx_a, locked_a} !== 6'b1_0000_0) begin
      $display("FAIL code_illegal: got %b want 100000", {code_a, tidx_a, locked_a}); fails++;
    end
    cyc(ill, 1'b0, 1'b0, 1'b0);
    cyc(12'hFFF, 1'b0, 1'b0, 1'b1);
    tests++;
    if (code_a !== 1'b0) begin $display("FAIL code_clear: got %b want 0", code_a); fails++; end
  endtask

  task automatic test_stall();
    int n0;
    for (int k = 1; k <= 6; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      cyc(tp(7), 1'b0, 1'b0, 1'b0);
      if (i == 64) begin
        tests++;
        if ({stall_a, locked_a} !== 2'b01) begin $display("FAIL stall_before: got %b want 01", {stall_a, locked_a}); fails++; end
      end
      if (i == 65) begin
        tests++;
        if ({stall_a, locked_a} !== 2'b10) begin $display("FAIL stall_hit: got %b want 10", {stall_a, locked_a}); fails++; end
      end
    end
    cyc(tp(7), 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    n0 = newt_tally;
    repeat (200) cyc(tp(7), 1'b0, 1'b1, 1'b0);
    tests++;
    if ({stall_a, locked_a} !== 2'b01) begin $display("FAIL stop_hold: got %b want 01", {stall_a, locked_a}); fails++; end
    repeat (4) cyc(tp(7), 1'b0, 1'b0, 1'b0);
    for (int k = 8; k <= 12; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(tp(1), 1'b0, 1'b0, 1'b0);
    tests++;
    if (newt_tally - n0 !== 7 || {seq_a, code_a, stall_a, locked_a} !== 4'b0001) begin
      $display("FAIL stop_resume: got newt %0d flags %b want 7 0001", newt_tally - n0, {seq_a, code_a, stall_a, locked_a});
      fails++;
    end
  endtask

  task automatic test_jam();
    int saved;
    repeat (5) cyc(tp(1), 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 12; k++) repeat (8) cyc(tp(k), 1'b0, 1'b0, 1'b0);
    saved = m_mct;
    cyc(tp(12), 1'b1, 1'b0, 1'b0);
    cyc(tp(12), 1'b1, 1'b0, 1'b0);
    tests++;
    if (locked_a !== 1'b0) begin $display("FAIL jam_unlock: got %b want 0", locked_a); fails++; end
    repeat (8) cyc(tp(12), 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(tp(12), 1'b0, 1'b0, 1'b0);
    cyc(tp(1), 1'b0, 1'b0, 1'b0);
    cyc(tp(1), 1'b0, 1'b0, 1'b0);
    tests++;
    if ({seq_a, code_a, stall_a, locked_a} !== 4'b0001) begin
      $display("FAIL jam_relock: got %b want 0001", {seq_a, code_a, stall_a, locked_a}); fails++;
    end
    tests++;
    if (mct_a !== 16'(saved)) begin $display("FAIL jam_mct: got %0d want %0d", mct_a, saved); fails++; end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    repeat (2) cyc(12'hFFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (17) ring(2);
    tests++;
    if (mct_b !== 4'd0 || mct_a !== 16'd16) begin
      $display("FAIL mct_wrap: got %0d/%0d want 0/16", mct_b, mct_a); fails++;
    end
    repeat (2) cyc(tp(1), 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(tp(2), 1'b0, 1'b0, 1'b0);
    cyc(tp(4), 1'b0, 1'b0, 1'b0);
    cyc(tp(4), 1'b0, 1'b0, 1'b1);
    tests++;
    if (seq_b !== 1'b1 || seq_a !== 1'b1) begin $display("FAIL clr_vs_new: got %b%b want 11", seq_a, seq_b); fails++; end
    cyc(tp(4), 1'b0, 1'b0, 1'b1);
    tests++;
    if (seq_a !== 1'b0 || mct_b !== 4'd1) begin $display("FAIL clr_after: got %b %0d want 0 1", seq_a, mct_b); fails++; end
  endtask

  task automatic test_random();
    int r, len, k;
    logic [11:0] pat;
    logic gj;
    logic [24:0] exp_a, act_a;
    logic [12:0] exp_b, act_b;
    k = 1;
    for (int seg = 0; seg < 320; seg++) begin
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 6);
      gj = 1'b0;
      if (r < 62) begin k = k % 12 + 1; pat = tp(k); end
      else if (r < 72) begin pat = 12'hFFF; len = $urandom_range(1, 2); end
      else if (r < 78) begin k = $urandom_range(1, 12); pat = tp(k); end
      else if (r < 83) begin pat = tp(k) & tp($urandom_range(1, 12)); end
      else if (r < 89) begin
        gj = 1'b1; len = $urandom_range(2, 5);
        if ($urandom_range(0, 3) == 0) pat = tp($urandom_range(1, 12)); else begin k = 12; pat = tp(12); end
      end
      else if (r < 93) begin pat = tp(k); len = $urandom_range(60, 70); end
      else begin k = 1; pat = tp(1); end
      for (int i = 0; i < len; i++) begin
        cyc(pat, gj, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        exp_a = {4'(m_tidx), m_newt, m_locked, 16'(m_mct), m_seq, m_code, m_stall};
        act_a = {tidx_a, newt_a, locked_a, mct_a, seq_a, code_a, stall_a};
        tests++;
        if (act_a !== exp_a) begin $display("FAIL random_main: got %h want %h", act_a, exp_a); fails++; end
        exp_b = {4'(m_tidx), m_newt, m_locked, 4'(m_mct), m_seq, m_code, m_stall};
        act_b = {tidx_b, newt_b, locked_b, mct_b, seq_b, code_b, stall_b};
        tests++;
        if (act_b !== exp_b) begin $display("FAIL random_cnt4: got %h want %h", act_b, exp_b); fails++; end
      end
    end
  endtask

  initial begin
    rst = 1'b1; t_n = 12'hFFF; gojam = 1'b0; stop = 1'b0; err_clr = 1'b0;
    model_edge(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_rings();
    test_skip();
    test_code();
    test_stall();
    test_jam();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timepulse_monitor.md
# timepulse_monitor

Consumer-side checker for the timer's time-pulse bus. It samples the twelve active-low time pulses T01_n..T12_n together with GOJAM and STOP, and encodes the one-hot pulse into a 4-bit index. It locks onto the T01→T12 ring, counts completed memory-cycle times (MCTs) and raises sticky alarms on illegal codes, out-of-order steps or stalls. It sits beside the timer on the same SIM_CLK, feeding the monitor/diagnostic path; it never drives the timer.

## Interface
Parameters:
- MAX_HOLD, 64: maximum SIM_CLK cycles one pulse may persist while STOP=0 and GOJAM=0.
- CNT_W, 16: width of MCT_CNT.

Ports:
- SIM_CLK  in  1  single clock; all state changes on its rising edge.
- SIM_RST  in  1  synchronous, active-high reset.
- T_n  in  12  T_n[k-1] = Tk_n (k=1..12), active low, level signals from the timer.
- GOJAM  in  1  timer restart; high forces re-sync.
- STOP  in  1  timer frozen; suspends stall detection.
- ERR_CLR  in  1  one-cycle pulse clearing sticky error flags.
- TIDX  out  4  decoded pulse index 1..12; 0 = none/illegal.
- NEWT  out  1  one-cycle strobe on each legal index step.
- LOCKED  out  1  high while in TRACK.
- MCT_CNT  out  CNT_W  count of legal T12→T01 steps, wraps modulo 2^CNT_W.
- SEQ_ERR, CODE_ERR, STALL_ERR  out  1 each  sticky alarms.

## Operation
- Stage 1 registers T_n, GOJAM and STOP. Stage 2 decodes the sampled pulses: exactly one low bit gives its index 1..12. All high gives 0 ("none"). Two or more low bits give 0 and "illegal".
- States:
  - SYNC (reset state).
  - TRACK.
  - JAM.
- SYNC:
  - Wait for decoded index 1 with GOJAM=0, then enter TRACK.
  - The entry cycle produces no NEWT and does not count.
- TRACK:
  - An index change to prev+1 (12→1 wraps) is legal. It pulses NEWT and reloads the hold counter. A 12→1 step also increments MCT_CNT.
  - Any other change to a nonzero index sets SEQ_ERR and goes to SYNC.
  - An illegal code sets CODE_ERR and goes to SYNC. "None" for one sampled cycle is tolerated (gap between pulses); two consecutive "none" cycles set CODE_ERR and go to SYNC.
  - Hold counter: increments each cycle the index is unchanged while STOP=0. Reaching MAX_HOLD sets STALL_ERR and goes to SYNC. While STOP=1 the counter holds its value and does not reload.
- JAM:
  - Entered from any state when sampled GOJAM=1. This overrides every other transition in the same cycle.
  - While in JAM, any index other than 12 or 0 sets CODE_ERR.
  - On sampled GOJAM=0, go to SYNC.
- Error flags: ERR_CLR clears all flags; a new error detected in the same cycle wins, and that flag stays set.
- MCT_CNT is retained across SYNC and JAM; only SIM_RST clears it.
- The index step has no width concerns. MCT_CNT is an unsigned CNT_W-bit counter and wraps from all-ones to 0 silently.

## Timing
- Latency: an input change at edge k is sampled at k+1; TIDX, NEWT, LOCKED, MCT_CNT and the flags update at k+2.
- NEWT is exactly one cycle wide. MCT_CNT increments in the same cycle as the NEWT for the 12→1 step.
- Reset values:
  - State SYNC.
  - TIDX=0, NEWT=0, LOCKED=0, MCT_CNT=0.
  - SEQ_ERR=CODE_ERR=STALL_ERR=0.
  - Hold counter 0.
- SIM_RST asserted mid-TRACK: all outputs return to reset values on the next edge. Pipeline registers clear to T_n=all-ones and GOJAM=STOP=0.
- TIDX is updated every cycle from the decode regardless of state. LOCKED goes high in the cycle TRACK is entered.

## Structure
- Shared package timepulse_pkg holds:
  - the state enum (SYNC, TRACK, JAM);
  - constants TIDX_NONE=0, TIDX_FIRST=1, TIDX_LAST=12;
  - the default MAX_HOLD.
- One combinational sub-module, tp_onehot_decode, maps 12-bit active-low pulses to a 4-bit index plus an illegal flag. It is reused by future monitor blocks.

## Test plan
- Reset, then drive T01..T12 each held for 8 cycles for 3 rings → LOCKED=1 two cycles after T01 is first seen; NEWT pulses 35 times; MCT_CNT=2; all flags 0.
- Ring running, skip T05 (T04→T06) → SEQ_ERR=1 and LOCKED=0 two edges later; the next T01 relocks; SEQ_ERR stays 1 until ERR_CLR.
- Drive T03_n and T04_n low together → CODE_ERR=1, TIDX=0, state SYNC.
- Hold T07 for 70 cycles with STOP=0 (MAX_HOLD=64) → STALL_ERR=1 at sampled hold 64. Repeat with STOP=1 for 200 cycles → no error; normal stepping resumes.
- Assert GOJAM mid-ring while T12 is forced → LOCKED=0, no errors. Release GOJAM → lock on the next T01; MCT_CNT is unchanged by the jam.
- With CNT_W=4, run 17 rings → MCT_CNT wraps to 0; assert ERR_CLR together with a new SEQ_ERR → SEQ_ERR=1.
